// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: request/result bundle for the sequential binary-to-BCD converter.
// Optional macro BCD_SIGNED_EN adds the neg result signal.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     blank;
`ifdef BCD_SIGNED_EN
  logic                  neg;

  // Requester side: issues conversions, observes results
  modport master (
    output start, bin,
    input  busy, done, bcd, blank, neg
  );

  // Converter side
  modport slave (
    input  start, bin,
    output busy, done, bcd, blank, neg
  );
`else
  // Requester side: issues conversions, observes results
  modport master (
    output start, bin,
    input  busy, done, bcd, blank
  );

  // Converter side
  modport slave (
    input  start, bin,
    output busy, done, bcd, blank
  );
`endif
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble binary-to-BCD converter with a
// leading-zero blank mask for the 7-segment digit decoders.
// One bit is consumed per cycle; a result is presented WIDTH+1 cycles after
// an accepted start and held until the next done pulse.
// Optional macro BCD_SIGNED_EN: treat bin as two's complement, convert the
// magnitude and report the sign on neg.
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic           clk,
  input  logic           reset,
  bin2bcd_seq_if.slave   bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  sh_reg, sh_next;
  logic [BW-1:0]     scratch_reg, scratch_next;
  logic [BW-1:0]     scratch_adj;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [BW-1:0]     bcd_reg;
  logic [DIGITS-1:0] blank_reg;
  logic [DIGITS-1:0] blank_calc;
  logic [WIDTH-1:0]  load_val;
  logic              accept;
  logic              finish;

  // Each scratch digit >= 5 gets +3 before the shift; the 4-bit add drops carry-out
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
      assign scratch_adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5)
                                      ? scratch_reg[4*gi +: 4] + 4'd3
                                      : scratch_reg[4*gi +: 4];
    end
  endgenerate

`ifdef BCD_SIGNED_EN
  logic neg_pend_reg;
  logic neg_reg;

  // Load the magnitude; the most negative value wraps to 2^(WIDTH-1), which is
  // exactly its magnitude when read as unsigned
  assign load_val = bus.bin[WIDTH-1]
                    ? (~bus.bin + {{(WIDTH-1){1'b0}}, 1'b1})
                    : bus.bin;
`else
  assign load_val = bus.bin;
`endif

  // Leading-zero mask of the final scratch value: a digit is blank when it and
  // every higher digit are zero; digit 0 always stays lit
  always_comb begin
    logic run;
    blank_calc = '0;
    run        = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run           = run & (scratch_next[4*i +: 4] == 4'd0);
      blank_calc[i] = run;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_next   = state_reg;
    sh_next      = sh_reg;
    scratch_next = scratch_reg;
    cnt_next     = cnt_reg;
    accept       = 1'b0;
    finish       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          accept       = 1'b1;
          sh_next      = load_val;
          scratch_next = '0;
          cnt_next     = CW'(WIDTH);
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_next, sh_next} = {scratch_adj, sh_reg} << 1;
        cnt_next                = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and working registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      sh_reg      <= '0;
      scratch_reg <= '0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      sh_reg      <= sh_next;
      scratch_reg <= scratch_next;
      cnt_reg     <= cnt_next;
    end
  end

  // Result registers: loaded on the edge that enters DONE so they are valid
  // throughout the done cycle, then held
  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_reg   <= '0;
      blank_reg <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else if (finish) begin
      bcd_reg   <= scratch_next;
      blank_reg <= blank_calc;
    end
  end

`ifdef BCD_SIGNED_EN
  // Sign captured at acceptance, published together with the digits
  always_ff @(posedge clk) begin
    if (reset) begin
      neg_pend_reg <= 1'b0;
      neg_reg      <= 1'b0;
    end else begin
      if (accept) begin
        neg_pend_reg <= bus.bin[WIDTH-1];
      end
      if (finish) begin
        neg_reg <= neg_pend_reg;
      end
    end
  end

  assign bus.neg = neg_reg;
`endif

  assign bus.busy  = (state_reg != IDLE);
  assign bus.done  = (state_reg == DONE);
  assign bus.bcd   = bcd_reg;
  assign bus.blank = blank_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq (16-bit, 5 digits).
// Build with +define+BCD_SIGNED_EN to exercise the signed variant.
module tb_bin2bcd_seq;

  localparam int WIDTH   = 16;
  localparam int DIGITS  = 5;
  localparam int LATENCY = WIDTH + 1;

  typedef struct {
    logic [19:0] bcd;
    logic [4:0]  blank;
    logic        neg;
  } exp_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   done_count;
  exp_t sb[$];

  bin2bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits by division, blank mask from the digit count
  function automatic exp_t model(input logic [15:0] v);
    exp_t        e;
    int unsigned m;
    int unsigned t;
    int          nd;
    m     = v;
    e.neg = 1'b0;
`ifdef BCD_SIGNED_EN
    if (v[15]) begin
      e.neg = 1'b1;
      m     = 32'd65536 - v;
    end
`endif
    nd = 1;
    t  = m;
    while (t >= 10) begin
      t  = t / 10;
      nd = nd + 1;
    end
    for (int i = 0; i < 5; i++) begin
      e.bcd[4*i +: 4] = 4'(m % 10);
      m               = m / 10;
      e.blank[i]      = (i >= nd);
    end
    return e;
  endfunction

  // Result monitor: every done pulse is matched against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.done) begin
      done_count++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("bcd", 32'(bus.bcd), 32'(e.bcd));
        check("blank", 32'(bus.blank), 32'(e.blank));
`ifdef BCD_SIGNED_EN
        check("neg", 32'(bus.neg), 32'(e.neg));
        $display("conv: bcd=%05h blank=%05b neg=%0b", bus.bcd, bus.blank, bus.neg);
`else
        $display("conv: bcd=%05h blank=%05b", bus.bcd, bus.blank);
`endif
      end
    end
  end

  // One conversion; optionally re-pulse start at cycles 5 and the done cycle
  task automatic do_conv(input logic [15:0] v, input bit interfere);
    int cyc;
    int d0;
    d0 = done_count;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = v;
    sb.push_back(model(v));
    @(negedge clk);
    bus.start = 1'b0;
    bus.bin   = $urandom;
    cyc = 1;
    check("busy_rise", 32'(bus.busy), 32'd1);
    while (!bus.done && cyc <= 100) begin
      if (interfere && cyc == 5) begin
        bus.start = 1'b1;
        bus.bin   = 16'd7;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check("latency", 32'(cyc), 32'(LATENCY));
    if (interfere) bus.start = 1'b1;  // start during the DONE cycle
    bus.bin = 16'd7;
    @(negedge clk);
    bus.start = 1'b0;
    check("done_pulse", 32'(bus.done), 32'd0);
    check("busy_fall", 32'(bus.busy), 32'd0);
    if (interfere) begin
      repeat (25) @(negedge clk);
      check("single_done", 32'(done_count), 32'(d0 + 1));
    end
  endtask

  initial begin
    int cyc;
    int d0;
    errors     = 0;
    checks     = 0;
    done_count = 0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.bin    = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_bcd", 32'(bus.bcd), 32'h00000);
    check("rst_blank", 32'(bus.blank), 32'b11110);
`ifdef BCD_SIGNED_EN
    check("rst_neg", 32'(bus.neg), 32'd0);
`endif

    do_conv(16'd0, 1'b0);
    do_conv(16'd65535, 1'b0);
    do_conv(16'd1234, 1'b0);
    do_conv(16'd9, 1'b0);
    do_conv(16'd10000, 1'b0);
    do_conv(16'h8000, 1'b0);
    do_conv(16'd500, 1'b0);
    do_conv(16'd100, 1'b1);
    for (int i = 0; i < 4; i++) begin
      do_conv(16'($urandom), 1'b0);
    end

    // Reset mid-conversion: no done, outputs back to reset values
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 16'd4321;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    reset = 1'b1;
    d0    = done_count;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_bcd", 32'(bus.bcd), 32'h00000);
    check("abort_blank", 32'(bus.blank), 32'b11110);
`ifdef BCD_SIGNED_EN
    check("abort_neg", 32'(bus.neg), 32'd0);
`endif
    repeat (25) @(negedge clk);
    check("abort_no_done", 32'(done_count), 32'(d0));
    do_conv(16'd42, 1'b0);

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout got=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Iterative binary-to-BCD converter using shift-and-add-3 (double dabble). It sits directly upstream of the wrapper's per-digit 7-segment decoders. It takes a binary value from the processor's output register and produces packed BCD digits, one nibble per display digit, so displayed values read in decimal rather than hex. It also produces a leading-zero blank mask, which the wrapper uses to force unused digits dark.

## Interface
Parameters:
- WIDTH, 16: binary input width, valid range 4..32.
- DIGITS, 5: number of BCD output digits. Must satisfy DIGITS ≥ ceil(WIDTH·log10 2).

Ports:
- clk  input  1  clock. Single clock domain.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request conversion of bin. Sampled only in IDLE.
- bin  input  WIDTH  binary operand, captured on an accepted start.
- busy  output  1  high while a conversion is in progress (SHIFT or DONE state).
- done  output  1  single-cycle pulse when bcd and blank update.
- bcd  output  4·DIGITS  packed BCD result. Digit 0 is at bits [3:0]. Held until the next done.
- blank  output  DIGITS  bit i=1 means digit i is a leading zero. Bit 0 is always 0.
- neg  output  1  sign of the last result. Present only when BCD_SIGNED_EN is defined.

## Operation
- **States:** IDLE, SHIFT, DONE.
- **IDLE:**
  - start=1 captures bin into the shift register.
  - It clears the BCD scratch register and loads the bit counter with WIDTH.
  - Next state is SHIFT.
- **SHIFT, each cycle:**
  - Every scratch digit ≥5 gets +3. Each digit adder is 4 bits wide and ignores carry-out.
  - The concatenation {scratch, shift register} then shifts left by 1.
  - The counter decrements.
  - When the counter reaches 1 in this cycle, the next state is DONE.
- **DONE:**
  - bcd ← scratch and blank ← computed mask.
  - done=1 for this cycle only; next state is IDLE.
- **Blank mask:**
  - Scan from the most significant digit down. A digit is blanked if it and all higher digits are zero.
  - Digit 0 is never blanked, so a value of 0 displays as "0".
- **start outside IDLE:** ignored, including in the DONE cycle. No queuing.
- **Output stability:** bin may change freely after acceptance. bcd, blank and neg do not change outside the DONE cycle.
- **Reset mid-conversion:** aborts the conversion. No done pulse is produced, and outputs return to their reset values.
- **Reset values:** state=IDLE, busy=0, done=0, bcd=0, blank={DIGITS-1{1}},0 (i.e. 1…10), neg=0.

## Timing
- start is accepted on edge 0.
- SHIFT occupies edges 1..WIDTH.
- DONE is entered after edge WIDTH. done is high during cycle WIDTH+1, and bcd, blank and neg are registered at that edge.
- Total latency from accepted start to done: WIDTH+1 cycles (17 for the default).
- busy rises the cycle after acceptance and falls with the exit from DONE.
- The earliest back-to-back start is accepted in the cycle after done. Throughput is one conversion per WIDTH+2 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- **BCD_SIGNED_EN defined:**
  - bin is treated as two's complement.
  - On acceptance, neg ← bin[WIDTH-1] and the shift register is loaded with |bin|.
  - The most negative value converts as magnitude 2^(WIDTH-1), e.g. -32768 → neg=1, bcd=0x32768.
  - The neg port exists and updates in the DONE cycle.
- **BCD_SIGNED_EN not defined:**
  - bin is unsigned.
  - The neg port and its logic are absent.

## Test plan
- After reset, check busy=0, done=0, bcd=0x00000 and blank=5'b11110. Then start with bin=0 → done in cycle 17, bcd=0x00000, blank=5'b11110.
- bin=16'd65535 → bcd=0x65535, blank=5'b00000, done high for exactly one cycle.
- bin=16'd1234 → bcd=0x01234, blank=5'b10000. Follow with bin=16'd9 → bcd=0x00009, blank=5'b11110.
- Start with bin=100, pulse start again with bin=7 at cycles 5 and 17 (the DONE cycle). Only one done occurs, with bcd=0x00100.
- Start with bin=4321, assert reset at cycle 8 → no done, outputs return to reset values. A subsequent start with bin=42 yields bcd=0x00042.
- With BCD_SIGNED_EN defined:
  - bin=16'hFFFF → neg=1, bcd=0x00001.
  - bin=16'h8000 → neg=1, bcd=0x32768.
  - bin=16'd500 → neg=0, bcd=0x00500.
